// File: rtl/button_event_decoder_pkg.sv
// Shared constants for the button path: FSM state encoding and 100 MHz timing defaults.
package button_event_decoder_pkg;

  // State encoding shared with the debouncer and PWM control blocks.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StPressed = ST_PRESSED,
    StLong    = ST_LONG
  } btn_state_e;

  // Default timing at 100 MHz.
  localparam int unsigned DEF_LONG_CYCLES   = 32'd100_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd20_000_000;   // 200 ms
  localparam int unsigned DEF_CNT_W         = 27;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press, release, click, long and repeat pulses.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             level_d;
  // Low for the first cycle after reset so level_d can pick up a button that was held through
  // reset; otherwise that held press would look like a fresh rise.
  logic             armed;
  logic             rise;
  logic             fall;

  assign rise = btn_level & ~level_d & armed;
  assign fall = ~btn_level & level_d;

  // Edge history and first-cycle arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_d <= btn_level;
      armed   <= 1'b1;
    end
  end

  // Event FSM with registered pulse outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        StIdle: begin
          // A fall here only follows a reset during a press and is dropped.
          if (rise) begin
            state       <= StPressed;
            hold_cnt    <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end
        end
        StPressed: begin
          // Release takes priority over reaching the long threshold.
          if (fall) begin
            state         <= StIdle;
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            held          <= 1'b0;
          end else if (hold_cnt == LongLast) begin
            state      <= StLong;
            hold_cnt   <= '0;
            long_pulse <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        StLong: begin
          if (fall) begin
            state         <= StIdle;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (hold_cnt == RepeatLast) begin
            hold_cnt     <= '0;
            repeat_pulse <= REPEAT_EN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= StIdle;
          hold_cnt <= '0;
          held     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected pulse vectors come from the press/hold
// timing rules applied to each stimulus pattern, queued up front and popped every cycle.
module tb_button_event_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;

  logic p_press, p_release, p_click, p_long, p_repeat, p_held;
  logic n_press, n_release, n_click, n_long, n_repeat, n_held;
  logic [5:0] obs;
  logic [5:0] obs_nr;

  int n_tests = 0;
  int n_fail  = 0;

  logic       stim_q[$];
  logic [5:0] exp_q[$];

  // Vector order: press, release, click, long, repeat, held.
  assign obs    = {p_press, p_release, p_click, p_long, p_repeat, p_held};
  assign obs_nr = {n_press, n_release, n_click, n_long, n_repeat, n_held};

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .press_pulse(p_press), .release_pulse(p_release), .click_pulse(p_click),
    .long_pulse(p_long), .repeat_pulse(p_repeat), .held(p_held)
  );

  button_event_decoder #(
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0), .CNT_W(8)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .press_pulse(n_press), .release_pulse(n_release), .click_pulse(n_click),
    .long_pulse(n_long), .repeat_pulse(n_repeat), .held(n_held)
  );

  function automatic void add(input logic v, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endfunction

  // Expected outputs: a rise at sample r held until the first low sample f gives press at r,
  // held over [r, f), release at f, click if f <= r+LONG, long at r+LONG if still held, and
  // repeats at r+LONG+n*REP while still held.
  function automatic void build_exp(input logic prev0, input bit ren);
    int         n;
    int         f;
    logic       prev;
    logic [5:0] e[];
    n = stim_q.size();
    e = new[n];
    foreach (e[i]) e[i] = '0;
    prev = prev0;
    for (int i = 0; i < n; i++) begin
      if (stim_q[i] && !prev) begin
        f = n;
        for (int j = n - 1; j > i; j--) if (!stim_q[j]) f = j;
        e[i][5] = 1'b1;
        for (int k = i; k < f; k++) e[k][0] = 1'b1;
        if (f < n) e[f][4] = 1'b1;
        if (f < n && f <= i + LONG) e[f][3] = 1'b1;
        if (i + LONG < f) e[i + LONG][2] = 1'b1;
        if (ren) for (int k = i + LONG + REP; k < f; k += REP) e[k][1] = 1'b1;
      end
      prev = stim_q[i];
    end
    foreach (e[i]) exp_q.push_back(e[i]);
  endfunction

  task automatic test_reset();
    logic [5:0] exp;
    rst_n = 1'b0;
    btn_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", obs, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Press and hold past the long threshold so held is up when reset hits.
    stim_q.delete();
    add(1'b0, 2);
    add(1'b1, 13);
    build_exp(1'b0, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_prehold cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 6'b0 || obs_nr !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b/%b want 000000", obs, obs_nr);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", obs, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Button still held through reset release, then dropped: no events at all.
    stim_q.delete();
    add(1'b1, 4);
    add(1'b0, 4);
    build_exp(1'b1, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_short_click();
    logic [5:0] exp;
    stim_q.delete();
    add(1'b0, 2);
    add(1'b1, 5);
    add(1'b0, 3);
    build_exp(1'b0, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL short_click cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] exp;
    stim_q.delete();
    add(1'b0, 1);
    add(1'b1, 25);
    add(1'b0, 3);
    build_exp(1'b0, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL long_hold cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_boundary();
    logic [5:0] exp;
    stim_q.delete();
    // Fall sampled with hold_cnt at LONG-1, then at REP-1 inside long-hold.
    add(1'b0, 1);
    add(1'b1, LONG);
    add(1'b0, 2);
    add(1'b1, LONG + REP);
    add(1'b0, 3);
    build_exp(1'b0, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL boundary cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_repeat_disabled();
    logic [5:0] exp;
    stim_q.delete();
    add(1'b0, 1);
    add(1'b1, 25);
    add(1'b0, 3);
    build_exp(1'b0, 1'b0);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs_nr !== exp) begin
        n_fail++;
        $display("FAIL repeat_disabled cyc %0d: got %b want %b", i, obs_nr, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    stim_q.delete();
    add(1'b0, 1);
    add(1'b1, 3);
    add(1'b0, 1);
    add(1'b1, 3);
    add(1'b0, 1);
    add(1'b1, 8);
    add(1'b0, 3);
    build_exp(1'b0, 1'b1);
    foreach (stim_q[i]) begin
      btn_level = stim_q[i];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_hold();
    test_boundary();
    test_repeat_disabled();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
